// File: rtl/mdio_controller_pkg.sv
// Shared encodings and field positions for the Clause-22 MDIO management controller.
package mdio_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_FRAME    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Transaction word layout, MSB first on the wire
    localparam int ST_MSB      = 31;
    localparam int ST_LSB      = 30;
    localparam int OP_MSB      = 29;
    localparam int OP_LSB      = 28;
    localparam int PHYADDR_MSB = 27;
    localparam int PHYADDR_LSB = 23;
    localparam int REGADDR_MSB = 22;
    localparam int REGADDR_LSB = 18;
    localparam int TA_MSB      = 17;
    localparam int TA_LSB      = 16;
    localparam int DATA_MSB    = 15;
    localparam int DATA_LSB    = 0;

    localparam int FRAME_BITS    = 32;
    localparam int PREAMBLE_BITS = 32;

    localparam logic [4:0] LAST_BIT     = 5'd31;
    localparam logic [4:0] TA_FIRST_BIT = 5'd14;
    localparam logic [4:0] RD_FIRST_BIT = 5'd16;

    function automatic logic op_is_read(input logic [31:0] word);
        return word[OP_MSB:OP_LSB] == OP_READ;
    endfunction

endpackage

// File: rtl/mdio_clk_phase.sv
// Two-cycle bit phase generator: phase 0 presents data, phase 1 raises MDC.
module mdio_clk_phase (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    output logic o_phase,
    output logic o_bit_end
);

    logic r_phase;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    assign o_phase   = r_phase;
    assign o_bit_end = i_run & r_phase;

endmodule

// File: rtl/mdio_controller.sv
// MDIO management-station controller (Clause 22). Optional preamble: MDIO_PREAMBLE_EN.
// state    | meaning
// IDLE     | bus released, waiting for MDIO_START
// PREAMBLE | 32 ones driven before the frame (MDIO_PREAMBLE_EN only)
// FRAME    | 32 frame bits shifted out; read data captured after turnaround
// DONE     | one-cycle completion, read data published
module mdio_controller
    import mdio_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        BUSY
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic        r_is_read;
    logic [15:0] r_rd_sr;
    logic [15:0] r_rd_data;
    logic        w_run;
    logic        w_phase;
    logic        w_bit_end;
    logic        w_last_bit;

    assign w_run      = (r_state == ST_FRAME) || (r_state == ST_PREAMBLE);
    assign w_last_bit = w_bit_end && (r_bit_cnt == LAST_BIT);

    mdio_clk_phase u_clk_phase (
        .i_clk     (CLK),
        .i_reset   (reset),
        .i_run     (w_run),
        .o_phase   (w_phase),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs decode registered state only, so no input reaches a pin combinationally
    always_comb begin
        w_next_state = r_state;
        MDC          = 1'b0;
        MDIO_OUT     = 1'b0;
        MDIO_OE      = 1'b0;
        BUSY         = 1'b1;
        DATA_RDY     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (MDIO_START) begin
`ifdef MDIO_PREAMBLE_EN
                    w_next_state = ST_PREAMBLE;
`else
                    w_next_state = ST_FRAME;
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            ST_PREAMBLE: begin
                MDC      = w_phase;
                MDIO_OE  = 1'b1;
                MDIO_OUT = 1'b1;
                if (w_last_bit) begin
                    w_next_state = ST_FRAME;
                end
            end
`endif
            ST_FRAME: begin
                MDC      = w_phase;
                MDIO_OE  = !(r_is_read && (r_bit_cnt >= TA_FIRST_BIT));
                MDIO_OUT = MDIO_OE & r_shift[31];
                if (w_last_bit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                DATA_RDY     = r_is_read;
                w_next_state = ST_IDLE;
            end
            default: begin
                BUSY         = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_is_read <= 1'b0;
            r_rd_sr   <= '0;
            r_rd_data <= '0;
        end else if (r_state == ST_IDLE) begin
            if (MDIO_START) begin
                r_shift   <= T_DATA;
                r_bit_cnt <= '0;
                r_is_read <= op_is_read(T_DATA);
                r_rd_sr   <= '0;
            end
        end else if (w_bit_end) begin
            r_bit_cnt <= w_last_bit ? 5'd0 : r_bit_cnt + 5'd1;
            if (r_state == ST_FRAME) begin
                r_shift <= {r_shift[30:0], 1'b0};
                if (r_is_read && (r_bit_cnt >= RD_FIRST_BIT)) begin
                    r_rd_sr <= {r_rd_sr[14:0], MDIO_IN};
                end
                // Last bit is folded in directly so RD_DATA is valid during DONE
                if (r_is_read && w_last_bit) begin
                    r_rd_data <= {r_rd_sr[14:0], MDIO_IN};
                end
            end
        end
    end

    assign RD_DATA = r_rd_data;

endmodule

// File: tb/tb_mdio_controller.sv
// Directed self-checking bench for mdio_controller; honours MDIO_PREAMBLE_EN when defined.
module tb_mdio_controller;

`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 64;
`else
    localparam int PRE = 0;
`endif

    logic        CLK;
    logic        reset;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    mdio_controller dut (
        .CLK        (CLK),
        .reset      (reset),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDC        (MDC),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .RD_DATA    (RD_DATA),
        .DATA_RDY   (DATA_RDY),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Starts a transaction in the current (IDLE) cycle and runs to the IDLE cycle after DONE.
    task automatic do_frame(input logic [31:0] word, input logic [15:0] phy, input bit hold,
                            input string tag);
        logic [31:0] rx, oe_v, exp_oe, pre_v;
        logic [63:0] mdc_v;
        logic [1:0]  done_bus;
        logic [15:0] rd_at;
        int          busy_n, rdy_n, rdy_c, f, k;
        bit          is_rd;
        is_rd = (word[29:28] == 2'b10);
        for (int b = 0; b < 32; b++) exp_oe[31-b] = is_rd ? (b < 14) : 1'b1;
        rx = '0; oe_v = '0; pre_v = '0; mdc_v = '0; done_bus = 2'b11; rd_at = '0;
        busy_n = 0; rdy_n = 0; rdy_c = -1;
        MDIO_START = 1'b1;
        T_DATA     = word;
        for (int c = 1; c <= 66 + PRE; c++) begin
            tick();
            if (c == 1) begin
                if (!hold) MDIO_START = 1'b0;
                T_DATA = ~word;
            end
            if (BUSY) busy_n++;
            f = c - PRE;
            if (c <= PRE) begin
                k = (c - 1) / 2;
                if ((c - 1) % 2 == 1) pre_v[31-k] = MDIO_OUT & MDIO_OE;
            end else if (f <= 64) begin
                k = (f - 1) / 2;
                mdc_v[64-f] = MDC;
                if ((f - 1) % 2 == 0) begin
                    oe_v[31-k] = MDIO_OE;
                    MDIO_IN = (k >= 16) ? phy[31-k] : 1'b0;
                end else begin
                    rx[31-k] = MDIO_OUT;
                end
            end else if (f == 65) begin
                done_bus = {MDC, MDIO_OE};
            end
            if (DATA_RDY) begin
                rdy_n++;
                rdy_c = c;
                rd_at = RD_DATA;
            end
        end
        MDIO_IN = 1'b0;
        check({tag, " rx_bits"}, 64'(rx), 64'(word & exp_oe));
        check({tag, " oe_bits"}, 64'(oe_v), 64'(exp_oe));
        check({tag, " mdc"}, mdc_v, 64'h5555_5555_5555_5555);
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(65 + PRE));
        check({tag, " done_bus"}, 64'(done_bus), 64'd0);
        check({tag, " idle_after"}, 64'({BUSY, MDC, MDIO_OE}), 64'd0);
        if (is_rd) begin
            check({tag, " rdy_count"}, 64'(rdy_n), 64'd1);
            check({tag, " rdy_cycle"}, 64'(rdy_c), 64'(65 + PRE));
            check({tag, " rd_data"}, 64'(rd_at), 64'(phy));
        end else begin
            check({tag, " rdy_count"}, 64'(rdy_n), 64'd0);
        end
`ifdef MDIO_PREAMBLE_EN
        check({tag, " preamble"}, 64'(pre_v), 64'hFFFF_FFFF);
`endif
    endtask

    initial begin
        int busy_n, rdy_n;
        reset      = 1'b1;
        MDIO_START = 1'b0;
        T_DATA     = '0;
        MDIO_IN    = 1'b0;
        repeat (3) tick();
        check("reset_state", 64'({MDC, MDIO_OUT, MDIO_OE, BUSY, DATA_RDY, RD_DATA}), 64'd0);
        reset = 1'b0;
        tick();

        do_frame(32'h5182_ABCD, 16'h0000, 1'b0, "wr");
        check("wr rd_hold", 64'(RD_DATA), 64'h0);
        do_frame(32'h6186_0000, 16'hBEEF, 1'b0, "rd");
        check("rd rd_hold", 64'(RD_DATA), 64'hBEEF);
        do_frame(32'h5182_ABCD, 16'h1357, 1'b0, "wr2");
        check("wr2 rd_hold", 64'(RD_DATA), 64'hBEEF);
        do_frame(32'h7182_5A5A, 16'hFFFF, 1'b0, "op11");
        check("op11 rd_hold", 64'(RD_DATA), 64'hBEEF);

        do_frame(32'h5182_0F0F, 16'h0000, 1'b1, "hold0");
        do_frame(32'h6186_0000, 16'hA5C3, 1'b1, "hold1");
        do_frame(32'h5182_F0F0, 16'h0000, 1'b0, "hold2");
        check("hold rd_hold", 64'(RD_DATA), 64'hA5C3);

        MDIO_START = 1'b1;
        T_DATA     = 32'h6186_0000;
        tick();
        MDIO_START = 1'b0;
        MDIO_IN    = 1'b1;
        repeat (29) tick();
        reset = 1'b1;
        tick();
        check("midrst outputs", 64'({MDC, MDIO_OUT, MDIO_OE, BUSY, DATA_RDY, RD_DATA}), 64'd0);
        reset   = 1'b0;
        MDIO_IN = 1'b0;
        busy_n  = 0;
        rdy_n   = 0;
        for (int c = 0; c < 80 + PRE; c++) begin
            tick();
            if (BUSY) busy_n++;
            if (DATA_RDY) rdy_n++;
        end
        check("midrst quiet", 64'(busy_n + rdy_n), 64'd0);
        do_frame(32'h6186_0000, 16'h1234, 1'b0, "post_rst");
        check("post_rst rd_hold", 64'(RD_DATA), 64'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
